// File: rtl/bounce_generator.sv
// Mechanical-contact emulator: every accepted edge of x opens a window in which z
// carries LFSR noise, after which z settles to the new level.
module bounce_generator #(
  parameter int          bounce_len = 8,
  parameter logic [15:0] seed       = 16'hACE1
) (
  input  logic ck,
  input  logic rst_n,
  input  logic x,
  input  logic en,
  output logic z,
  output logic busy
);

  localparam int          CW       = (bounce_len < 1) ? 1 : $clog2(bounce_len + 1);
  localparam logic [15:0] SEED_EFF = (seed == 16'h0000) ? 16'h0001 : seed;
  localparam logic [15:0] TAPS     = 16'hB400;
  localparam logic [CW-1:0] CNT_INIT = CW'((bounce_len > 0) ? bounce_len - 1 : 0);

  typedef enum logic {IDLE, BOUNCE} state_e;

  state_e        state_q, state_d;
  logic          target_q, target_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          z_q, z_d;
  logic          busy_q, busy_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          r;

  assign r    = lfsr_q[0];
  assign z    = z_q;
  assign busy = busy_q;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= 1'b0;
      cnt_q    <= '0;
      z_q      <= 1'b0;
      busy_q   <= 1'b0;
      lfsr_q   <= SEED_EFF;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      z_q      <= z_d;
      busy_q   <= busy_d;
      lfsr_q   <= lfsr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    z_d      = z_q;
    busy_d   = busy_q;
    // Galois right shift; free-running so the pattern depends only on time since reset
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
    case (state_q)
      IDLE: begin
        if (x != target_q) begin
          target_d = x;
          if (!en || bounce_len == 0) begin
            z_d = x;
          end else begin
            cnt_d   = CNT_INIT;
            z_d     = r;
            busy_d  = 1'b1;
            state_d = BOUNCE;
          end
        end else begin
          z_d = target_q;
        end
      end
      BOUNCE: begin
        // en is deliberately ignored here: a window always runs to completion
        if (x != target_q) begin
          target_d = x;
          cnt_d    = CNT_INIT;
          z_d      = r;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          z_d   = r;
        end else begin
          z_d     = target_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bounce_generator.sv
// Directed bench for bounce_generator: window timing, restart, pass-through,
// async reset, determinism and a debouncer chain.
module tb_bounce_generator;

  logic ck = 1'b0, rst_n = 1'b0, x = 1'b0, en = 1'b1;
  logic z, busy, z0, busy0;
  int checks = 0, errors = 0;

  always #5 ck = ~ck;

  bounce_generator #(.bounce_len(8), .seed(16'hACE1)) dut (
    .ck(ck), .rst_n(rst_n), .x(x), .en(en), .z(z), .busy(busy));

  bounce_generator #(.bounce_len(0), .seed(16'h0000)) dut0 (
    .ck(ck), .rst_n(rst_n), .x(x), .en(en), .z(z0), .busy(busy0));

  // Reference noise source; mprev holds the value the DUT consumed at the last edge
  logic [15:0] m, mprev;
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction
  always @(posedge ck or negedge rst_n)
    if (!rst_n) begin m <= 16'hACE1; mprev <= 16'hACE1; end
    else begin mprev <= m; m <= lfsr_next(m); end

  // Downstream debouncer: output follows input once stable for 10 cycles
  logic db_cand, db_out;
  int db_cnt;
  always @(posedge ck or negedge rst_n)
    if (!rst_n) begin db_cand <= 1'b0; db_out <= 1'b0; db_cnt <= 0; end
    else if (z != db_cand) begin db_cand <= z; db_cnt <= 0; end
    else if (db_cnt == 9) db_out <= db_cand;
    else db_cnt <= db_cnt + 1;

  task automatic tick();
    @(posedge ck); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; x = 1'b0; en = 1'b1;
    tick();
    #3 rst_n = 1'b1;
  endtask

  task automatic check_window(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL %s busy[%0d]: got %b want 1", name, i, busy); end
      checks++;
      if (z !== mprev[0]) begin errors++; $display("FAIL %s noise[%0d]: got %b want %b", name, i, z, mprev[0]); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; x = 1'b0; en = 1'b1;
    tick(); tick();
    checks++;
    if (z !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_out: got z=%b busy=%b want 0 0", z, busy); end
    checks++;
    if (dut.lfsr_q !== 16'hACE1) begin errors++; $display("FAIL reset_lfsr: got %h want ace1", dut.lfsr_q); end
    checks++;
    if (dut0.lfsr_q !== 16'h0001) begin errors++; $display("FAIL seed0_lfsr: got %h want 0001", dut0.lfsr_q); end
    #3 rst_n = 1'b1;
  endtask

  task automatic test_bounce();
    int toggles;
    logic pz;
    do_reset();
    repeat (9) tick();
    x = 1'b1; toggles = 0; pz = z;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy[%0d]: got %b want 1", i, busy); end
      checks++;
      if (z !== mprev[0]) begin errors++; $display("FAIL t1_noise[%0d]: got %b want %b", i, z, mprev[0]); end
      checks++;
      if (z0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL len0_pass[%0d]: got z=%b busy=%b want 1 0", i, z0, busy0); end
      if (z !== pz) toggles++;
      pz = z;
    end
    tick();
    checks++;
    if (busy !== 1'b0 || z !== 1'b1) begin errors++; $display("FAIL t1_settle: got z=%b busy=%b want 1 0", z, busy); end
    checks++;
    if (toggles == 0) begin errors++; $display("FAIL t1_toggle: got %0d toggles want >0", toggles); end
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || z !== 1'b1) begin errors++; $display("FAIL t1_hold: got z=%b busy=%b want 1 0", z, busy); end
  endtask

  task automatic run_trace(output logic [39:0] tr);
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (i == 5) x = 1'b1;
      if (i == 20) x = 1'b0;
      if (i == 24) x = 1'b1;
      tick();
      tr[i] = z;
    end
  endtask

  task automatic test_determinism();
    logic [39:0] a, b;
    run_trace(a);
    run_trace(b);
    checks++;
    if (a !== b) begin errors++; $display("FAIL t2_repeat: got %h want %h", b, a); end
    checks++;
    if (a[39] !== 1'b1) begin errors++; $display("FAIL t2_final: got %b want 1", a[39]); end
  endtask

  task automatic test_restart();
    do_reset();
    repeat (3) tick();
    x = 1'b1;
    check_window("t3_first", 4);
    x = 1'b0;
    check_window("t3_restart", 8);
    tick();
    checks++;
    if (busy !== 1'b0 || z !== 1'b0) begin errors++; $display("FAIL t3_settle: got z=%b busy=%b want 0 0", z, busy); end
  endtask

  task automatic test_passthrough();
    do_reset();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      x = (i >= 3 && i < 6) ? 1'b1 : 1'b0;
      tick();
      checks++;
      if (z !== x || busy !== 1'b0) begin errors++; $display("FAIL t4_pass[%0d]: got z=%b busy=%b want %b 0", i, z, busy, x); end
    end
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (2) tick();
    x = 1'b1;
    check_window("t5_pre", 5);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (z !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t5_async: got z=%b busy=%b want 0 0", z, busy); end
    checks++;
    if (dut.lfsr_q !== 16'hACE1) begin errors++; $display("FAIL t5_lfsr: got %h want ace1", dut.lfsr_q); end
    #2 rst_n = 1'b1;
    check_window("t5_post", 8);
    tick();
    checks++;
    if (busy !== 1'b0 || z !== 1'b1) begin errors++; $display("FAIL t5_settle: got z=%b busy=%b want 1 0", z, busy); end
  endtask

  task automatic test_debouncer();
    int rises, falls;
    logic pd;
    do_reset();
    rises = 0; falls = 0; pd = db_out;
    for (int i = 0; i < 120; i++) begin
      x = (i >= 5 && i < 55) ? 1'b1 : 1'b0;
      tick();
      if (db_out && !pd) rises++;
      if (!db_out && pd) falls++;
      pd = db_out;
    end
    checks++;
    if (rises != 1) begin errors++; $display("FAIL t6_rises: got %0d want 1", rises); end
    checks++;
    if (falls != 1) begin errors++; $display("FAIL t6_falls: got %0d want 1", falls); end
    checks++;
    if (db_out !== 1'b0) begin errors++; $display("FAIL t6_final: got %b want 0", db_out); end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_determinism();
    test_restart();
    test_passthrough();
    test_async_reset();
    test_debouncer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
